// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the tester-side scan chain master.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  function automatic int nbytes_f(input int nregs);
    return (nregs + 7) / 8;
  endfunction

  function automatic int lastbits_f(input int nregs);
    return nregs - 8 * (nbytes_f(nregs) - 1);
  endfunction

endpackage

// File: rtl/scan_capture.sv
// Capture side: samples scan_so one cycle after each shift, assembles bytes
// and presents them through a single holding register with valid/ready.
module scan_capture
  import scan_pkg::*;
#(
  parameter int NREGS = 1918
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       se_i,
  input  logic       so_i,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  output logic       hold_free_o,
  output logic       se_dly_o
);

  localparam int NBYTES   = nbytes_f(NREGS);
  localparam int LASTBITS = lastbits_f(NREGS);
  localparam int BYTE_W   = $clog2(NBYTES + 1);

  logic              se_dly_q, se_dly_d;
  logic [7:0]        asm_q, asm_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              last_byte;
  logic              byte_full;

  always_comb begin
    se_dly_d   = se_i;
    asm_d      = asm_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    last_byte  = (byte_q == BYTE_W'(NBYTES - 1));
    byte_full  = last_byte ? (idx_q == 3'(LASTBITS - 1)) : (idx_q == 3'd7);

    if (hold_vld_q && out_ready_i) hold_vld_d = 1'b0;

    // The FSM guarantees the holding register is free whenever a byte completes.
    if (se_dly_q) begin
      asm_d[idx_q] = so_i;
      if (byte_full) begin
        hold_d     = asm_d;
        hold_vld_d = 1'b1;
        asm_d      = '0;
        idx_d      = '0;
        byte_d     = last_byte ? '0 : byte_q + BYTE_W'(1);
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      se_dly_q   <= 1'b0;
      asm_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      se_dly_q   <= se_dly_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign out_data_o  = hold_q;
  assign out_valid_o = hold_vld_q;
  assign hold_free_o = !hold_vld_q || out_ready_i;
  assign se_dly_o    = se_dly_q;

endmodule

// File: rtl/scan_driver.sv
// Tester-side scan master: loads NREGS bits from a byte stream into the chain
// while returning the bits shifted out as a byte stream.
module scan_driver
  import scan_pkg::*;
#(
  parameter int NREGS = 1918
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       scan_tm_o,
  output logic       scan_se_o,
  output logic       scan_si_o,
  input  logic       scan_so_i
);

  localparam int NBYTES   = nbytes_f(NREGS);
  localparam int LASTBITS = lastbits_f(NREGS);
  localparam int BYTE_W   = $clog2(NBYTES + 1);
  localparam int TOT_W    = $clog2(NREGS + 1);

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [3:0]        bits_q, bits_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [TOT_W-1:0]  tot_q, tot_d;
  logic              se_q, se_d;
  logic              si_q, si_d;
  logic              fin1_q, fin1_d;
  logic              fin2_q, fin2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;

  logic              clr;
  logic              accept;
  logic              fin_now;
  logic              shift_ok;
  logic              hold_free;
  logic              se_dly;

  assign clr = rst_i || abort_i;

  scan_capture #(
    .NREGS(NREGS)
  ) u_capture (
    .clk_i      (clk_i),
    .rst_i      (clr),
    .se_i       (se_q),
    .so_i       (scan_so_i),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .hold_free_o(hold_free),
    .se_dly_o   (se_dly)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bits_d  = bits_q;
    byte_d  = byte_q;
    tot_d   = tot_q;
    se_d    = 1'b0;
    si_d    = si_q;
    fin1_d  = 1'b0;
    fin2_d  = fin1_q;
    accept  = rdy_q && in_valid_i;
    fin_now = (bits_q == 4'd1);
    // A byte-completing shift also waits out any earlier completion still in flight.
    shift_ok = !fin_now || (hold_free && !fin1_q && !fin2_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          byte_d  = '0;
          tot_d   = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          sr_d    = in_data_i;
          bits_d  = (byte_q == BYTE_W'(NBYTES - 1)) ? 4'(LASTBITS) : 4'd8;
          byte_d  = byte_q + BYTE_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_ok) begin
          se_d   = 1'b1;
          si_d   = sr_q[0];
          fin1_d = fin_now;
          sr_d   = {1'b0, sr_q[7:1]};
          bits_d = bits_q - 4'd1;
          tot_d  = tot_q + TOT_W'(1);
          if (fin_now) state_d = (tot_d < TOT_W'(NREGS)) ? FETCH : DRAIN;
        end
      end
      DRAIN: begin
        if (!se_q && !se_dly && !out_valid_o) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rdy_d  = (state_d == FETCH);
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bits_q  <= '0;
      byte_q  <= '0;
      tot_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      fin1_q  <= 1'b0;
      fin2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bits_q  <= bits_d;
      byte_q  <= byte_d;
      tot_q   <= tot_d;
      se_q    <= se_d;
      si_q    <= si_d;
      fin1_q  <= fin1_d;
      fin2_q  <= fin2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign in_ready_o = rdy_q;
  assign scan_tm_o  = busy_q;
  assign scan_se_o  = se_q;
  assign scan_si_o  = si_q;

endmodule

// File: doc/scan_driver.md
Name: scan_driver

Overview:
- Tester-side master for the CSOC scan chain. It is the other end of the serial interface exposed by the chip (test_tm, test_se, data_i[0] in, data_o[0] out).
- Takes a byte stream of load-pattern bits and shifts exactly NREGS bits into the chain.
- Simultaneously captures the NREGS bits shifted out and returns them as a byte stream.
- Sits between the bench/host interface and the CSOC scan pins.

Parameters:
- NREGS, 1918, scan chain length in flops.
- NBYTES (localparam), ceil(NREGS/8) = 240, bytes per pattern in each direction.
- LASTBITS (localparam), NREGS - 8*(NBYTES-1) = 6, valid bits in the final byte.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  one-cycle pulse, begin a pattern; ignored unless IDLE
- abort_i  in  1  return to IDLE from any state
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the final output byte is accepted
- in_data_i  in  8  pattern byte, LSB shifted first
- in_valid_i  in  1  pattern byte valid
- in_ready_o  out  1  pattern byte accepted when in_valid_i && in_ready_o
- out_data_o  out  8  captured byte, first captured bit in LSB
- out_valid_o  out  1  captured byte valid
- out_ready_i  in  1  captured byte consumed when out_valid_o && out_ready_i
- scan_tm_o  out  1  test mode, to test_tm
- scan_se_o  out  1  shift enable, to test_se
- scan_si_o  out  1  serial in, to data_i[0]
- scan_so_i  in  1  serial out, from data_o[0]

Behaviour:
- Reset (rst_i, synchronous, priority over everything): state IDLE; all outputs 0; all counters, the shift register, the assembly register and the holding register cleared.
- States:
  - IDLE: start_i -> FETCH.
  - FETCH: in_ready_o=1. On accept, load the 8-bit shift register and set the bit count to 8, or to LASTBITS for byte NBYTES-1. Then -> SHIFT.
  - SHIFT: issue shift cycles. When the byte's bits are exhausted, go to FETCH if shifted < NREGS, else -> DRAIN.
  - DRAIN: wait for the final sample and for the holding register to empty -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE.
- scan_tm_o = busy_o. scan_se_o and scan_si_o are driven from flops.
- A shift cycle drives scan_se_o=1 and scan_si_o=current bit, then advances the shift register, bit count and total count.
- Total number of scan_se_o-high cycles per pattern is exactly NREGS. They are not necessarily contiguous.
- Capture latency is 1: se_d = scan_se_o delayed one cycle. At the end of every cycle with se_d=1, scan_so_i is written into the assembly register at the current bit index.
- The DUT output holds while se=0, so stalls are safe.
- The assembly register completes a byte after 8 samples, or after LASTBITS samples for the last byte (unused high bits 0). The completed byte moves to the holding register and out_valid_o=1 until it is accepted.
- Stall rule: the shift cycle that will produce the final bit of an output byte is issued only if the holding register is empty or is being accepted in that cycle. Other shift cycles are never stalled by the output side. No byte is ever dropped or overwritten.
- Throughput without backpressure: 9 cycles per byte (1 fetch + 8 shift).
- abort_i (lower priority than rst_i): same effect as reset on the next edge. Partial input and output bytes are discarded and no done_o is produced. Chain contents are whatever was shifted so far.
- start_i while busy: ignored. in_valid_i outside FETCH: ignored (in_ready_o=0).
- Counters: bit index 3 bits, byte/total count 11 bits minimum, sized from NREGS with $clog2.

Decomposition:
- Package scan_pkg: state enum (IDLE, FETCH, SHIFT, DRAIN, DONE) and functions computing NBYTES and LASTBITS from NREGS.
- One natural sub-module: scan_capture. It holds se_d, the assembly register, the holding register and the out_valid/out_ready handshake, and exports a hold_free flag to the FSM for the stall rule.

Test Plan:
- 1. NREGS=16 with csoc(NREGS=16) attached; reset, start, send 0xA5,0x3C -> outputs 0x00,0x00; exactly 16 se-high cycles; done_o one pulse; busy_o drops the cycle after done.
- 2. Second pattern 0x0F,0xF0 -> outputs 0xA5,0x3C. Third pattern -> outputs 0x0F,0xF0.
- 3. Default NREGS=1918: pattern byte i = i[7:0], run twice -> second run returns bytes i for i<239; byte 239 = 0xEF & 0x3F = 0x2F; exactly 1918 se-high cycles per run.
- 4. Backpressure: hold out_ready_i=0 for 20 cycles after the first out_valid_o -> scan_se_o stays low before the 16th bit; the byte stays stable; all bytes match test 2 after release.
- 5. Input gaps: deassert in_valid_i for 5 random cycles between bytes -> scan_se_o low during gaps; output identical to the gap-free run.
- 6. Assert abort_i, then on a separate run rst_i, after 7 shift cycles -> next cycle busy_o=0, scan_se_o=0, out_valid_o=0, no done_o; a subsequent full run completes normally.
